cronometro_param: RTL and testbench

//  Parametrised stopwatch core: N-digit BCD counter advanced by an internal tick prescaler, and a
//  4-state control FSM (ZEROED/STOPPED/PAUSED/COUNTING) driven by active-low push buttons.

---
 rtl/cronometro_param.sv | 178 +++++++++++++++++
 tb/tb_cronometro_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cronometro_param.sv
// Parametrised BCD stopwatch core with button synchronisers, a four-state control FSM,
// selectable overflow policy, lap-style display freeze and a packed 7-segment bus.
module cronometro_param #(
    parameter int N_DIGITS       = 4,
    parameter int TICK_DIV       = 5000000,
    parameter int OVF_MODE       = 0,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  conta_n,
    input  logic                  para_n,
    input  logic                  pausa_n,
    input  logic                  zera_n,
    output logic [4*N_DIGITS-1:0] disp_bcd,
    output logic [7*N_DIGITS-1:0] seg,
    output logic [1:0]            state,
    output logic                  running,
    output logic                  ovf
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ZEROED   = 2'd0,
        STOPPED  = 2'd1,
        PAUSED   = 2'd2,
        COUNTING = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [4*N_DIGITS-1:0] r_cnt;
    logic [4*N_DIGITS-1:0] r_disp;
    logic [PW-1:0]         r_presc;
    logic                  r_ovf;
    logic [3:0]            r_sync1;
    logic [3:0]            r_sync2;
    logic [3:0]            r_prev;

    logic [3:0]            w_press;
    logic                  w_running;
    logic                  w_tick;
    logic                  w_allNines;
    logic                  w_ovfNow;
    logic                  w_carry;
    logic [4*N_DIGITS-1:0] w_cntInc;
    logic [4*N_DIGITS-1:0] w_cntNext;

    // Button order in the vectors is {zera, para, pausa, conta}; flops preset to released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
        end else begin
            r_sync1 <= {zera_n, para_n, pausa_n, conta_n};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_press   = ~r_sync2 & r_prev;
    assign w_running = (r_state == COUNTING) || (r_state == PAUSED);
    assign w_tick    = w_running && (r_presc == PRE_MAX);
    assign w_ovfNow  = w_tick && w_allNines;

    always_comb begin
        w_cntInc   = r_cnt;
        w_allNines = 1'b1;
        w_carry    = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_cnt[4*i +: 4] != 4'd9) begin
                w_allNines = 1'b0;
            end
            if (w_carry) begin
                if (r_cnt[4*i +: 4] == 4'd9) begin
                    w_cntInc[4*i +: 4] = 4'd0;
                end else begin
                    w_cntInc[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
    end

    // Saturating mode keeps the all-9s value; the other modes restart from zero.
    always_comb begin
        w_cntNext = r_cnt;
        if (w_tick) begin
            if (!w_allNines) begin
                w_cntNext = w_cntInc;
            end else if (OVF_MODE != 1) begin
                w_cntNext = '0;
            end
        end
    end

    // Only the single highest-priority press is acted on; overflow overrides any press.
    always_comb begin
        w_stateNext = r_state;
        if (w_ovfNow) begin
            if (OVF_MODE == 1) begin
                w_stateNext = STOPPED;
            end else if (OVF_MODE == 2) begin
                w_stateNext = ZEROED;
            end
        end else if (w_press[3]) begin
            w_stateNext = ZEROED;
        end else if (w_press[2]) begin
            w_stateNext = STOPPED;
        end else if (w_press[1]) begin
            if ((r_state == ZEROED) || (r_state == COUNTING)) begin
                w_stateNext = PAUSED;
            end
        end else if (w_press[0]) begin
            w_stateNext = COUNTING;
        end
    end

    // The prescaler is held outside the running states so a resume keeps the sub-tick phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ZEROED;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_presc <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_ovf   <= w_ovfNow;
            if (w_stateNext == ZEROED) begin
                r_cnt   <= '0;
                r_disp  <= '0;
                r_presc <= '0;
            end else begin
                if (w_running) begin
                    r_presc <= w_tick ? '0 : r_presc + PW'(1);
                end
                r_cnt <= w_cntNext;
                if (w_stateNext == COUNTING) begin
                    r_disp <= w_cntNext;
                end
            end
        end
    end

    function automatic logic [6:0] segDecode(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    always_comb begin
        seg = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            seg[7*i +: 7] = SEG_ACTIVE_LOW ? ~segDecode(r_disp[4*i +: 4])
                                           : segDecode(r_disp[4*i +: 4]);
        end
    end

    assign disp_bcd = r_disp;
    assign state    = r_state;
    assign running  = w_running;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_cronometro_param.sv
// Scoreboard bench for cronometro_param: three 2-digit instances (one per overflow mode) share
// the buttons; an integer-level stopwatch model predicts every cycle's outputs.
module tb_cronometro_param;

    localparam int TICK = 4;
    localparam int MAXV = 99;

    typedef struct packed {
        logic [1:0]  st;
        logic [7:0]  disp;
        logic [13:0] seg;
        logic        run;
        logic        ovf;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic contaN, paraN, pausaN, zeraN;
    logic [3:0] btn;

    logic [7:0]  dispW [3];
    logic [13:0] segW  [3];
    logic [1:0]  stW   [3];
    logic        runW  [3];
    logic        ovfW  [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int nCompares    = 0;
    int nMiscompares = 0;

    int mSt [3];
    int mCnt[3];
    int mDisp[3];
    int mPre[3];
    logic [3:0] s1, s2, s3;

    always #5 clock = ~clock;

    cronometro_param #(.N_DIGITS(2), .TICK_DIV(TICK), .OVF_MODE(0), .SEG_ACTIVE_LOW(1'b1)) dut0 (
        .clock(clock), .reset(reset), .conta_n(contaN), .para_n(paraN), .pausa_n(pausaN),
        .zera_n(zeraN), .disp_bcd(dispW[0]), .seg(segW[0]), .state(stW[0]),
        .running(runW[0]), .ovf(ovfW[0]));

    cronometro_param #(.N_DIGITS(2), .TICK_DIV(TICK), .OVF_MODE(1), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clock(clock), .reset(reset), .conta_n(contaN), .para_n(paraN), .pausa_n(pausaN),
        .zera_n(zeraN), .disp_bcd(dispW[1]), .seg(segW[1]), .state(stW[1]),
        .running(runW[1]), .ovf(ovfW[1]));

    cronometro_param #(.N_DIGITS(2), .TICK_DIV(TICK), .OVF_MODE(2), .SEG_ACTIVE_LOW(1'b1)) dut2 (
        .clock(clock), .reset(reset), .conta_n(contaN), .para_n(paraN), .pausa_n(pausaN),
        .zera_n(zeraN), .disp_bcd(dispW[2]), .seg(segW[2]), .state(stW[2]),
        .running(runW[2]), .ovf(ovfW[2]));

    function automatic logic [7:0] toBcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] segOf(input int d);
        case (d)
            0:       return 7'b1111110;
            1:       return 7'b0110000;
            2:       return 7'b1101101;
            3:       return 7'b1111001;
            4:       return 7'b0110011;
            5:       return 7'b1011011;
            6:       return 7'b1011111;
            7:       return 7'b1110000;
            8:       return 7'b1111111;
            9:       return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic exp_t makeExp(input int st, input int disp, input logic ovfBit);
        exp_t e;
        e.st   = 2'(st);
        e.disp = toBcd(disp);
        e.seg  = ~{segOf(disp / 10), segOf(disp % 10)};
        e.run  = (st == 2) || (st == 3);
        e.ovf  = ovfBit;
        return e;
    endfunction

    task automatic pushExp(input int m, input exp_t e);
        if (m == 0) q0.push_back(e);
        else if (m == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    // Stopwatch model: states 0=zeroed 1=stopped 2=paused 3=counting, values as plain integers.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 = 4'hF;
            s2 = 4'hF;
            s3 = 4'hF;
            q0.delete();
            q1.delete();
            q2.delete();
            for (int m = 0; m < 3; m++) begin
                mSt[m] = 0; mCnt[m] = 0; mDisp[m] = 0; mPre[m] = 0;
                pushExp(m, makeExp(0, 0, 1'b0));
            end
        end else begin
            logic [3:0] pr;
            pr = ~s2 & s3;
            for (int m = 0; m < 3; m++) begin
                int  nst;
                bit  run, tick, ov;
                run  = (mSt[m] == 2) || (mSt[m] == 3);
                tick = run && (mPre[m] == TICK - 1);
                ov   = tick && (mCnt[m] == MAXV);
                nst  = mSt[m];
                if (ov) begin
                    if (m == 1) nst = 1;
                    else if (m == 2) nst = 0;
                end else if (pr[3]) nst = 0;
                else if (pr[2]) nst = 1;
                else if (pr[1]) begin
                    if (mSt[m] == 0 || mSt[m] == 3) nst = 2;
                end else if (pr[0]) nst = 3;
                if (nst == 0) begin
                    mCnt[m] = 0; mDisp[m] = 0; mPre[m] = 0;
                end else begin
                    if (run) mPre[m] = tick ? 0 : mPre[m] + 1;
                    if (tick) mCnt[m] = ov ? ((m == 1) ? mCnt[m] : 0) : mCnt[m] + 1;
                    if (nst == 3) mDisp[m] = mCnt[m];
                end
                mSt[m] = nst;
                pushExp(m, makeExp(mSt[m], mDisp[m], ov));
            end
            s3 = s2;
            s2 = s1;
            s1 = {zeraN, paraN, pausaN, contaN};
        end
    end

    task automatic checkOutput(input int m, input exp_t e);
        exp_t act;
        act.st   = stW[m];
        act.disp = dispW[m];
        act.seg  = segW[m];
        act.run  = runW[m];
        act.ovf  = ovfW[m];
        nCompares++;
        if (act !== e) begin
            nMiscompares++;
            $display("[TB] FAIL dut%0d outputs @%0t: got st=%0d disp=%h seg=%b run=%b ovf=%b, expected st=%0d disp=%h seg=%b run=%b ovf=%b",
                     m, $time, act.st, act.disp, act.seg, act.run, act.ovf,
                     e.st, e.disp, e.seg, e.run, e.ovf);
        end
    endtask

    // Monitor: consumes one model prediction per instance each cycle, away from the active edge.
    always @(negedge clock) begin
        if (q0.size() > 0) checkOutput(0, q0.pop_front());
        if (q1.size() > 0) checkOutput(1, q1.pop_front());
        if (q2.size() > 0) checkOutput(2, q2.pop_front());
    end

    task automatic applyStimulus(input logic [3:0] btnN, input int cycles);
        {zeraN, paraN, pausaN, contaN} = btnN;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic press(input logic [3:0] btnN, input int idle);
        applyStimulus(btnN, 2);
        applyStimulus(4'b1111, idle);
    endtask

    initial begin
        int thr[4];
        reset = 1'b1;
        {zeraN, paraN, pausaN, contaN} = 4'b1111;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        press(4'b1110, 45);
        press(4'b1101, 12);
        press(4'b1110, 20);
        press(4'b1011, 100);
        press(4'b1110, 30);
        applyStimulus(4'b1111, 420);
        press(4'b1110, 50);
        press(4'b0010, 10);
        press(4'b1011, 10);
        press(4'b1101, 10);
        press(4'b1110, 10);

        thr = '{30, 120, 150, 300};
        btn = 4'b1111;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (btn[b]) begin
                    if ($urandom_range(thr[b]) == 0) btn[b] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    btn[b] = 1'b1;
                end
            end
            applyStimulus({btn[3], btn[2], btn[1], btn[0]}, 1);
        end

        press(4'b1110, 30);
        #2 reset = 1'b1;
        #1;
        for (int m = 0; m < 3; m++) begin
            checkOutput(m, makeExp(0, 0, 1'b0));
        end
        applyStimulus(4'b0000, 3);
        reset = 1'b0;
        applyStimulus(4'b0000, 20);
        applyStimulus(4'b1111, 10);

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiscompares);
        $finish;
    end

endmodule
